serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL take parameter WIDTH, default 8, as the operand width in bits (legal values 2..32).
REQ-002 The module SHALL take parameter DIGIT, default 1, as the bits processed per cycle; DIGIT SHALL divide WIDTH exactly.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: request a new operation.
REQ-006 The module SHALL have port sub, input, 1 bit: 0 means A+B, 1 means A-B.
REQ-007 The module SHALL have ports A and B, input, WIDTH bits each: unsigned operands.
REQ-008 The module SHALL have port F, output, WIDTH+1 bits: the result, where F[WIDTH] is the final carry.
REQ-009 The module SHALL have port overflow, output, 1 bit: two's-complement signed overflow of the result.
REQ-010 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse when F is valid.

Function
REQ-012 The state machine SHALL have the states IDLE, RUN and DONE.
REQ-013 In IDLE, a high start at a rising edge SHALL latch A, B and sub, preset the carry to sub, clear the digit counter and enter RUN.
REQ-014 When sub=1, the latched B SHALL be bitwise inverted, so the operation is A + ~B + 1.
REQ-015 Each RUN cycle SHALL add one DIGIT-bit slice, LSB slice first, with the stored carry, write the slice result into F and update the carry.
REQ-016 After N = WIDTH/DIGIT RUN cycles, the state SHALL be DONE: F[WIDTH] equals the final carry, overflow equals carry-in XOR carry-out of the MSB, and done is high for exactly that cycle.
REQ-017 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-018 Latency SHALL be N+1 edges from the start edge to the done cycle (for example 9 edges for WIDTH=8, DIGIT=1 and 3 edges for WIDTH=8, DIGIT=4).
REQ-019 busy SHALL be high in RUN and DONE, and low in IDLE.
REQ-020 start SHALL be ignored while busy is high; operand changes after the start edge SHALL NOT affect the result.
REQ-021 When start is high in the DONE cycle, it SHALL be ignored; a new operation is accepted from IDLE only.
REQ-022 F and overflow SHALL hold their values from DONE until the next accepted start; during RUN, F[WIDTH-1:0] is partially updated and is not valid.
REQ-023 For subtraction, F[WIDTH]=1 SHALL mean no borrow (A >= B unsigned).
REQ-024 The carry chain SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-025 While rst_n is low, the block SHALL immediately force state IDLE, F=0, overflow=0, busy=0, done=0, carry=0 and counter=0.
REQ-026 When rst_n is asserted mid-operation, the block SHALL abort the operation, and no done SHALL follow.
REQ-027 The first start SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-028 The state encoding and the default WIDTH and DIGIT values SHALL live in the shared package adder_pkg.
REQ-029 The slice add SHALL be a combinational sub-module digit_adder, parameterised by DIGIT, with inputs a, b and cin and outputs s and cout.
REQ-030 The counter width SHALL be clog2(N), with a minimum of 1 bit.

Verification
REQ-031 With WIDTH=3, DIGIT=1, the bench SHALL run all 64 A,B combinations with sub=0, and F SHALL equal A+B (4 bits) on each done pulse; for example 7+7 gives F=14.
REQ-032 With WIDTH=8, DIGIT=1, sub=1, A=0x05, B=0x07, the bench SHALL check F[7:0]=0xFE, F[8]=0, overflow=0 and done exactly 9 edges after start.
REQ-033 With WIDTH=8, DIGIT=4, A=0x7F, B=0x01, add, the bench SHALL check F=0x080 and overflow=1 at 3 edges.
REQ-034 With WIDTH=8, the bench SHALL pulse start again while busy and change A/B mid-run, and SHALL check the result still matches the originally latched operands with only one done pulse.
REQ-035 With WIDTH=8, the bench SHALL pull rst_n low at RUN cycle 4 and SHALL check that all outputs are 0 immediately, that no done follows, and that the next start produces a correct result.
REQ-036 The bench SHALL hold start high continuously, and SHALL check that operations are accepted only from IDLE, giving a done every N+2 edges.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state encoding, default sizes and counter sizing for the serial adder
package adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DIGIT = 1;

   // A single-slice adder still needs a one-bit counter register.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational DIGIT-bit slice adder with carry in and carry out
module digit_adder #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout
);

   logic [DIGIT:0] sum;

   assign sum  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
   assign s    = sum[DIGIT-1:0];
   assign cout = sum[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial add/subtract unit, one DIGIT-bit slice per cycle, LSB first
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIGIT = DEF_DIGIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH:0]   F,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = cnt_width(N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH:0]   f_q, f_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [DIGIT-1:0] a_sl, b_sl, s_sl;
   logic             cout_sl;

   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int i = 0; i < N; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            a_sl = a_q[i*DIGIT +: DIGIT];
            b_sl = b_q[i*DIGIT +: DIGIT];
         end
      end
   end

   digit_adder #(
      .DIGIT(DIGIT)
   ) u_digit (
      .a   (a_sl),
      .b   (b_sl),
      .cin (carry_q),
      .s   (s_sl),
      .cout(cout_sl)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      f_d     = f_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = sub ? ~B : B;
               carry_d = sub;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int i = 0; i < N; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  f_d[i*DIGIT +: DIGIT] = s_sl;
               end
            end
            carry_d = cout_sl;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               state_d    = ST_DONE;
               f_d[WIDTH] = cout_sl;
               // Same-sign operands giving an opposite-sign sum is exactly cin^cout at the MSB.
               ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_sl[DIGIT-1] != a_q[WIDTH-1]);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         f_q     <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         f_q     <= f_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign F        = f_q;
   assign overflow = ovf_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder in three configurations
module tb_serial_adder;

   logic clk;
   logic rst_n;

   logic       start3, sub3;
   logic [2:0] a3, b3;
   logic [3:0] f3;
   logic       ov3, busy3, done3;

   logic       start8, sub8;
   logic [7:0] a8, b8;
   logic [8:0] f8;
   logic       ov8, busy8, done8;

   logic       start84, sub84;
   logic [7:0] a84, b84;
   logic [8:0] f84;
   logic       ov84, busy84, done84;

   int total;
   int bad;

   serial_adder #(.WIDTH(3), .DIGIT(1)) u_w3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .sub(sub3), .A(a3), .B(b3),
      .F(f3), .overflow(ov3), .busy(busy3), .done(done3)
   );

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .A(a8), .B(b8),
      .F(f8), .overflow(ov8), .busy(busy8), .done(done8)
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) u_w84 (
      .clk(clk), .rst_n(rst_n), .start(start84), .sub(sub84), .A(a84), .B(b84),
      .F(f84), .overflow(ov84), .busy(busy84), .done(done84)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] get_f(input int which);
      case (which)
         0:       return {5'd0, f3};
         1:       return f8;
         default: return f84;
      endcase
   endfunction

   function automatic logic get_ov(input int which);
      case (which)
         0:       return ov3;
         1:       return ov8;
         default: return ov84;
      endcase
   endfunction

   function automatic logic get_busy(input int which);
      case (which)
         0:       return busy3;
         1:       return busy8;
         default: return busy84;
      endcase
   endfunction

   function automatic logic get_done(input int which);
      case (which)
         0:       return done3;
         1:       return done8;
         default: return done84;
      endcase
   endfunction

   task automatic set_in(input int which, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic st);
      case (which)
         0: begin a3 = a[2:0]; b3 = b[2:0]; sub3 = s; start3 = st; end
         1: begin a8 = a; b8 = b; sub8 = s; start8 = st; end
         default: begin a84 = a; b84 = b; sub84 = s; start84 = st; end
      endcase
   endtask

   task automatic set_start(input int which, input logic st);
      case (which)
         0:       start3 = st;
         1:       start8 = st;
         default: start84 = st;
      endcase
   endtask

   // One full operation: start edge counts as edge 1, done must appear after exp_edges edges.
   task automatic do_op(input int which, input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [8:0] exp_f, input logic exp_ov, input logic check_ov,
                        input int exp_edges, input string tag);
      int edges;
      set_in(which, a, b, s, 1'b1);
      tick();
      set_start(which, 1'b0);
      edges = 1;
      while (!get_done(which) && edges < 40) begin
         tick();
         edges++;
      end
      chk({tag, "_edges"}, edges, exp_edges);
      chk({tag, "_f"}, {23'd0, get_f(which)}, {23'd0, exp_f});
      if (check_ov) chk({tag, "_ov"}, {31'd0, get_ov(which)}, {31'd0, exp_ov});
      chk({tag, "_busy_done"}, {31'd0, get_busy(which)}, 32'd1);
      tick();
      chk({tag, "_done_pulse"}, {31'd0, get_done(which)}, 32'd0);
      chk({tag, "_idle"}, {31'd0, get_busy(which)}, 32'd0);
   endtask

   initial begin
      int dones;
      int first_edge;
      int prev_edge;
      logic [8:0] f_at_done;
      logic [3:0] exp3;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      set_in(0, 8'd0, 8'd0, 1'b0, 1'b0);
      set_in(1, 8'd0, 8'd0, 1'b0, 1'b0);
      set_in(2, 8'd0, 8'd0, 1'b0, 1'b0);
      #1;
      chk("rst_f8", {23'd0, f8}, 32'd0);
      chk("rst_ov8", {31'd0, ov8}, 32'd0);
      chk("rst_busy8", {31'd0, busy8}, 32'd0);
      chk("rst_done8", {31'd0, done8}, 32'd0);
      chk("rst_f84", {23'd0, f84}, 32'd0);
      chk("rst_f3", {28'd0, f3}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8; b++) begin
            exp3 = 4'(a) + 4'(b);
            do_op(0, 8'(a), 8'(b), 1'b0, {5'd0, exp3}, 1'b0, 1'b0, 4,
                  $sformatf("add3_%0d_%0d", a, b));
         end
      end

      do_op(1, 8'h05, 8'h07, 1'b1, 9'h0FE, 1'b0, 1'b1, 9, "sub8_05_07");
      do_op(1, 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, 1'b1, 9, "add8_ff_01");
      do_op(1, 8'h80, 8'h01, 1'b1, 9'h17F, 1'b1, 1'b1, 9, "sub8_80_01");
      do_op(1, 8'h07, 8'h05, 1'b1, 9'h102, 1'b0, 1'b1, 9, "sub8_07_05");
      do_op(2, 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 1'b1, 3, "add84_7f_01");
      do_op(2, 8'h00, 8'h01, 1'b1, 9'h0FF, 1'b0, 1'b1, 3, "sub84_00_01");
      do_op(2, 8'h80, 8'h80, 1'b0, 9'h100, 1'b1, 1'b1, 3, "add84_80_80");

      // Restart attempt and operand change while the first operation is still running.
      set_in(1, 8'h3C, 8'h0F, 1'b0, 1'b1);
      tick();
      start8 = 1'b0;
      tick();
      tick();
      set_in(1, 8'hFF, 8'hFF, 1'b1, 1'b1);
      dones      = 0;
      first_edge = 0;
      f_at_done  = '0;
      for (int e = 4; e <= 20; e++) begin
         tick();
         if (e == 5) start8 = 1'b0;
         if (done8) begin
            dones++;
            if (first_edge == 0) begin
               first_edge = e;
               f_at_done  = f8;
            end
         end
      end
      chk("midrun_edges", first_edge, 9);
      chk("midrun_f", {23'd0, f_at_done}, 32'h04B);
      chk("midrun_dones", dones, 1);

      // Asynchronous reset during the fourth RUN cycle.
      set_in(1, 8'h12, 8'h34, 1'b0, 1'b1);
      tick();
      start8 = 1'b0;
      for (int e = 0; e < 4; e++) tick();
      chk("abort_busy_before", {31'd0, busy8}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_f", {23'd0, f8}, 32'd0);
      chk("abort_ov", {31'd0, ov8}, 32'd0);
      chk("abort_busy", {31'd0, busy8}, 32'd0);
      chk("abort_done", {31'd0, done8}, 32'd0);
      tick();
      rst_n = 1'b1;
      dones = 0;
      for (int e = 0; e < 12; e++) begin
         tick();
         if (done8) dones++;
      end
      chk("abort_no_done", dones, 0);
      do_op(1, 8'h12, 8'h34, 1'b0, 9'h046, 1'b0, 1'b1, 9, "after_abort");

      // Start held high: a new operation only from IDLE, so done every N+2 edges.
      set_in(2, 8'h11, 8'h22, 1'b0, 1'b1);
      dones     = 0;
      prev_edge = 0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (done84) begin
            dones++;
            chk($sformatf("hold_f_%0d", e), {23'd0, f84}, 32'h033);
            if (prev_edge == 0) chk("hold_first", e, 3);
            else chk($sformatf("hold_gap_%0d", e), e - prev_edge, 4);
            prev_edge = e;
         end
      end
      chk("hold_dones", dones, 5);
      start84 = 1'b0;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
